// File: rtl/dram_addr_mapper.sv
// dram_addr_mapper: registered L2-to-DRAM address split with open-row hit tracking and 2-entry skid buffer
module dram_addr_mapper #(
    parameter int ADDR_WIDTH   = 20,
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int CNT_WIDTH    = 16,
    localparam int BANK_W = $clog2(NUM_OF_BANKS),
    localparam int ROW_W  = $clog2(NUM_OF_ROWS),
    localparam int COL_W  = $clog2(NUM_OF_COLS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            cfg_mode,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BANK_W-1:0]     out_bank_id,
    output logic [ROW_W-1:0]      out_row_id,
    output logic [COL_W-1:0]      out_col_id,
    output logic                  out_row_hit,
    output logic                  out_err,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);
    localparam int USED_W = COL_W + BANK_W + ROW_W;
    localparam int RW = BANK_W + ROW_W + COL_W + 2;
    logic [COL_W-1:0] col;
    logic [BANK_W-1:0] bank0, bank1, bank;
    logic [ROW_W-1:0] row0, row1, row;
    logic err, hit, accept, pop, skid_valid, wr;
    logic [RW-1:0] res, out_q, skid_q;
    logic [NUM_OF_BANKS-1:0] tv;
    logic [ROW_W-1:0] tr [NUM_OF_BANKS];
    assign col   = in_addr[COL_W-1:0];
    assign bank0 = in_addr[COL_W+BANK_W-1:COL_W];
    assign row0  = in_addr[USED_W-1:COL_W+BANK_W];
    assign row1  = in_addr[COL_W+ROW_W-1:COL_W];
    assign bank1 = in_addr[USED_W-1:COL_W+ROW_W];
    assign accept = in_valid && in_ready;
    assign pop = out_valid && out_ready;
    assign in_ready = !skid_valid;
    assign wr = accept && !err;
    assign res = {bank, row, col, hit, err};
    assign {out_bank_id, out_row_id, out_col_id, out_row_hit, out_err} = out_q;
    always_comb begin
        bank = cfg_mode == 2'd1 ? bank1 : cfg_mode == 2'd2 ? bank0 ^ row0[BANK_W-1:0] : bank0;
        row  = cfg_mode == 2'd1 ? row1 : row0;
        err  = cfg_mode == 2'd3 || |(in_addr >> USED_W);
        hit  = !err && !flush && tv[bank] && tr[bank] == row;
    end
    always_ff @(posedge clk)
        if (wr) tr[bank] <= row;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tv         <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            tv <= (flush ? '0 : tv) | (wr ? NUM_OF_BANKS'(1) << bank : '0);
            if (wr && hit && ~&hit_count) hit_count <= hit_count + CNT_WIDTH'(1);
            if (wr && !hit && ~&miss_count) miss_count <= miss_count + CNT_WIDTH'(1);
            if (!out_valid || pop) begin
                out_valid  <= skid_valid || accept;
                out_q      <= skid_valid ? skid_q : accept ? res : out_q;
                skid_valid <= 1'b0;
            end else if (accept) begin
                skid_valid <= 1'b1;
                skid_q     <= res;
            end
        end
    end
endmodule
